key_sampler: RTL

KEY_SAMPLER -- requirements
Module: key_sampler

---
 rtl/key_sampler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/key_sampler.sv
// key_sampler: synchronizes a raw push-button level, samples it on a slow
// prescaler tick and emits a one-cycle ready pulse per pressed sample.
// With KEY_SAMPLER_LOCKOUT_EN defined, a "done" from the downstream press
// detector locks the sampler until the key has been seen released on
// RELEASE_TICKS consecutive ticks. Without the macro the sampler is always
// armed, done is ignored and locked is tied low.
module key_sampler #(
  parameter int DIV           = 50000,
  parameter int RELEASE_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  input  logic done,
  output logic ready,
  output logic locked,
  output logic key_sync
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;
  logic          tick;
  logic          ready_q;
  logic          ready_d;

  // Two-flop synchronizer for the asynchronous key level.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let sync2_q take the old sync1_q, giving
    // a true two-stage pipeline regardless of statement order.
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign key_sync = sync2_q;

  // Free-running prescaler; tick marks its last count.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  end

  // Prescaler register; never stalled or restarted by the FSM.
  always_ff @(posedge clk) begin
    if (reset) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_d;
  end

`ifdef KEY_SAMPLER_LOCKOUT_EN

  typedef enum logic {
    ST_ARMED  = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [7:0] REL_LAST = 8'(RELEASE_TICKS - 1);

  state_e     state_q;
  state_e     state_d;
  logic [7:0] rel_cnt_q;
  logic [7:0] rel_cnt_d;

  // Next state, release counter and ready request.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    ready_d   = 1'b0;
    case (state_q)
      ST_ARMED: begin
        if (done) begin
          // done wins over a coincident tick: no ready for that sample.
          state_d   = ST_LOCKED;
          rel_cnt_d = '0;
        end else if (tick && sync2_q) begin
          ready_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (tick) begin
          if (sync2_q) begin
            rel_cnt_d = '0;
          end else if (rel_cnt_q == REL_LAST) begin
            // Count would reach RELEASE_TICKS: re-arm instead of storing it.
            state_d   = ST_ARMED;
            rel_cnt_d = '0;
          end else begin
            rel_cnt_d = rel_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // State and release counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ARMED;
      rel_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rel_cnt_q <= rel_cnt_d;
    end
  end

  assign locked = (state_q == ST_LOCKED);

`else

  // done has no effect when the lockout is not built.
  logic unused_done;
  assign unused_done = done;

  // Always armed: every pressed sample requests a ready pulse.
  always_comb begin
    ready_d = tick & sync2_q;
  end

  assign locked = 1'b0;

`endif

  // Registered ready pulse; reset suppresses a pulse due on that edge.
  always_ff @(posedge clk) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= ready_d;
  end

  assign ready = ready_q;

endmodule
